// File: rtl/conf_reg_sink_if.sv
// Write-beat channel from the CONF output port into the register sink.
// Handshake: a beat {c_addr, c_data} transfers on a rising clock edge where
// c_valid && c_ready are both high; while c_valid is high and c_ready is low
// the master holds c_addr/c_data stable, and c_ready never depends on c_valid.
interface conf_reg_sink_if #(
    parameter int c_addr_WIDTH = 8,
    parameter int c_data_WIDTH = 32
);
    logic                    c_valid;
    logic [c_addr_WIDTH-1:0] c_addr;
    logic [c_data_WIDTH-1:0] c_data;
    logic                    c_ready;

    modport master (output c_valid, output c_addr, output c_data, input c_ready);
    modport slave  (input c_valid, input c_addr, input c_data, output c_ready);
endinterface

// File: rtl/conf_reg_sink.sv
// Configuration register sink: buffers (addr, data) write beats in a small
// FIFO and commits them in order into a register bank with combinational
// readback. Out-of-range beats are dropped and counted.
module conf_reg_sink #(
    parameter int c_addr_WIDTH = 8,
    parameter int c_data_WIDTH = 32,
    parameter int NUM_REGS     = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    conf_reg_sink_if.slave                conf,
    input  logic                          stall,
    input  logic                          err_clr,
    input  logic [c_addr_WIDTH-1:0]       rd_addr,
    output logic [c_data_WIDTH-1:0]       rd_data,
    output logic                          wr_pulse,
    output logic [c_addr_WIDTH-1:0]       wr_idx,
    output logic                          err_sticky,
    output logic [7:0]                    err_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

    logic [c_addr_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [c_data_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [c_data_WIDTH-1:0] regs_q      [NUM_REGS];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]        level_q, level_d;
    logic                    wr_pulse_q;
    logic [c_addr_WIDTH-1:0] wr_idx_q;
    logic                    err_sticky_q;
    logic [7:0]              err_cnt_q;

    logic                    push, pop, head_legal;
    logic [c_addr_WIDTH-1:0] head_addr;
    logic [c_data_WIDTH-1:0] head_data;

    // Handshake and commit decode; ready comes from registered occupancy only
    always_comb begin
        conf.c_ready = rst_n && (level_q < DEPTH_LVL);
        push         = conf.c_valid && conf.c_ready;
        pop          = (level_q != '0) && !stall;
        head_addr    = fifo_addr_q[rd_ptr_q];
        head_data    = fifo_data_q[rd_ptr_q];
        head_legal   = int'(head_addr) < NUM_REGS;
        level_d      = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // FIFO storage; contents are only meaningful behind the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= conf.c_addr;
            fifo_data_q[wr_ptr_q] <= conf.c_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    // Register bank: legal head entries are written when popped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (pop && head_legal) begin
            regs_q[head_addr[RIDX_W-1:0]] <= head_data;
        end
    end

    // Commit reporting and error bookkeeping; clear beats a same-cycle error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pulse_q   <= 1'b0;
            wr_idx_q     <= '0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            wr_pulse_q <= pop && head_legal;
            if (pop && head_legal) wr_idx_q <= head_addr;
            if (err_clr) begin
                err_sticky_q <= 1'b0;
                err_cnt_q    <= '0;
            end else if (pop && !head_legal) begin
                err_sticky_q <= 1'b1;
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    // Combinational readback; out-of-range addresses read as zero
    always_comb begin
        rd_data = '0;
        if (int'(rd_addr) < NUM_REGS) rd_data = regs_q[rd_addr[RIDX_W-1:0]];
    end

    assign wr_pulse   = wr_pulse_q;
    assign wr_idx     = wr_idx_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;
    assign fifo_level = level_q;
endmodule

// File: tb/tb_conf_reg_sink.sv
// Directed bench for conf_reg_sink: reset, single write, backpressure,
// out-of-range beats, repeated address and mid-operation reset.
module tb_conf_reg_sink;
    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        err_clr;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wr_pulse;
    logic [7:0]  wr_idx;
    logic        err_sticky;
    logic [7:0]  err_cnt;
    logic [2:0]  fifo_level;

    int n_pass;
    int n_total;

    conf_reg_sink_if #(.c_addr_WIDTH(8), .c_data_WIDTH(32)) cif ();

    conf_reg_sink #(
        .c_addr_WIDTH(8), .c_data_WIDTH(32), .NUM_REGS(16), .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .conf       (cif.slave),
        .stall      (stall),
        .err_clr    (err_clr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_pulse   (wr_pulse),
        .wr_idx     (wr_idx),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .fifo_level (fifo_level)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [31:0] d);
        cif.c_valid = v;
        cif.c_addr  = a;
        cif.c_data  = d;
    endtask

    task automatic read_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
        rd_addr = a;
        #1;
        check(tag, rd_data, exp);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        stall   = 1'b0;
        err_clr = 1'b0;
        rd_addr = '0;
        drive(1'b0, 8'h00, 32'h0);

        // Reset state
        #2;
        check("rst_ready", 32'(cif.c_ready), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(cif.c_ready), 32'h1);
        check("post_rst_pulse", 32'(wr_pulse), 32'h0);
        for (int i = 0; i < 16; i++) read_check("rst_rd", 8'(i), 32'h0);

        // Single write addr 3
        tick();
        drive(1'b1, 8'd3, 32'hDEADBEEF);
        tick();                                   // edge N: accepted
        drive(1'b0, 8'd0, 32'h0);
        check("single_level", 32'(fifo_level), 32'h1);
        check("single_nopulse", 32'(wr_pulse), 32'h0);
        tick();                                   // edge N+1: committed
        check("single_pulse", 32'(wr_pulse), 32'h1);
        check("single_idx", 32'(wr_idx), 32'h3);
        check("single_level0", 32'(fifo_level), 32'h0);
        rd_addr = 8'd3;
        #1;
        check("single_rd", rd_data, 32'hDEADBEEF);
        tick();
        check("single_pulse_end", 32'(wr_pulse), 32'h0);
        check("single_idx_hold", 32'(wr_idx), 32'h3);

        // Backpressure: stall with five beats offered
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8 + i), 32'h100 + 32'(i));
            tick();
        end
        drive(1'b1, 8'd12, 32'h104);
        check("full_level", 32'(fifo_level), 32'h4);
        check("full_ready", 32'(cif.c_ready), 32'h0);
        tick();                                   // beat 5 refused
        check("full_hold_level", 32'(fifo_level), 32'h4);
        check("full_hold_ready", 32'(cif.c_ready), 32'h0);
        stall = 1'b0;
        tick();                                   // pop beat 0, no push
        check("drain0_idx", 32'(wr_idx), 32'h8);
        check("drain0_pulse", 32'(wr_pulse), 32'h1);
        check("drain0_level", 32'(fifo_level), 32'h3);
        check("drain0_ready", 32'(cif.c_ready), 32'h1);
        tick();                                   // pop beat 1, push beat 5
        drive(1'b0, 8'd0, 32'h0);
        check("drain1_idx", 32'(wr_idx), 32'h9);
        check("drain1_level", 32'(fifo_level), 32'h3);
        tick();
        check("drain2_idx", 32'(wr_idx), 32'hA);
        check("drain2_pulse", 32'(wr_pulse), 32'h1);
        tick();
        check("drain3_idx", 32'(wr_idx), 32'hB);
        tick();
        check("drain4_idx", 32'(wr_idx), 32'hC);
        check("drain4_pulse", 32'(wr_pulse), 32'h1);
        check("drain4_level", 32'(fifo_level), 32'h0);
        for (int i = 0; i < 5; i++) read_check("drain_rd", 8'(8 + i), 32'h100 + 32'(i));

        // Out-of-range beat
        tick();
        drive(1'b1, 8'd20, 32'hCAFEF00D);
        tick();
        drive(1'b0, 8'd0, 32'h0);
        tick();
        check("bad_sticky", 32'(err_sticky), 32'h1);
        check("bad_cnt", 32'(err_cnt), 32'h1);
        check("bad_nopulse", 32'(wr_pulse), 32'h0);
        read_check("bad_rd3", 8'd3, 32'hDEADBEEF);
        read_check("bad_rd12", 8'd12, 32'h104);
        read_check("bad_rd20", 8'd20, 32'h0);

        // 300 more bad beats saturate the counter
        tick();
        drive(1'b1, 8'd200, 32'h0);
        for (int i = 0; i < 300; i++) tick();
        drive(1'b0, 8'd0, 32'h0);
        tick();
        tick();
        check("sat_cnt", 32'(err_cnt), 32'hFF);
        check("sat_sticky", 32'(err_sticky), 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_cnt", 32'(err_cnt), 32'h0);
        check("clr_sticky", 32'(err_sticky), 32'h0);

        // Clear wins over a same-cycle error
        drive(1'b1, 8'd20, 32'h0);
        tick();
        drive(1'b0, 8'd0, 32'h0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_prio_cnt", 32'(err_cnt), 32'h0);
        check("clr_prio_sticky", 32'(err_sticky), 32'h0);

        // Repeated address, last write wins
        drive(1'b1, 8'd5, 32'h1);
        tick();
        drive(1'b1, 8'd5, 32'h2);
        tick();
        drive(1'b0, 8'd0, 32'h0);
        check("rep1_pulse", 32'(wr_pulse), 32'h1);
        check("rep1_idx", 32'(wr_idx), 32'h5);
        rd_addr = 8'd5;
        #1;
        check("rep1_rd", rd_data, 32'h1);
        tick();
        check("rep2_pulse", 32'(wr_pulse), 32'h1);
        check("rep2_idx", 32'(wr_idx), 32'h5);
        check("rep2_rd", rd_data, 32'h2);
        tick();
        check("rep_end_pulse", 32'(wr_pulse), 32'h0);

        // Reset with three beats pending
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(7 + i), 32'hA0 + 32'(i));
            tick();
        end
        drive(1'b0, 8'd0, 32'h0);
        check("pre_rst_level", 32'(fifo_level), 32'h3);
        rd_addr = 8'd3;
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(cif.c_ready), 32'h0);
        check("mid_rst_level", 32'(fifo_level), 32'h0);
        check("mid_rst_idx", 32'(wr_idx), 32'h0);
        check("mid_rst_rd", rd_data, 32'h0);
        tick();
        rst_n = 1'b1;
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_nopulse", 32'(wr_pulse), 32'h0);
            check("post_rst_level0", 32'(fifo_level), 32'h0);
        end
        for (int i = 0; i < 3; i++) read_check("post_rst_rd", 8'(7 + i), 32'h0);
        read_check("post_rst_rd5", 8'd5, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
